// File: rtl/biquad_coef_ctrl.sv
// Biquad coefficient controller: shadow bank written by the host,
// swapped atomically into the active bank on a sample strobe.
//
// Ports:
//   CLK, RST            clock, async active-low reset
//   WR_VALID/WR_READY   write handshake; WR_SECT/WR_IDX/WR_DATA payload
//   COMMIT_REQ          request swap (sampled in IDLE/LOAD)
//   COMMIT_ACK          one-cycle pulse in the swap cycle
//   SAMPLE_STB          sample-boundary strobe
//   COEF_OUT            active coefficients, 80 bits per section
//   FLUSH               delay-line clear pulse after a swap
//   BUSY                commit in progress
//   ERR                 sticky illegal-write flag, cleared by a swap
module biquad_coef_ctrl #(
   parameter int N_SECT          = 4,
   parameter int SECT_W          = 2,
   parameter bit FLUSH_ON_COMMIT = 1'b1,
   parameter int FLUSH_CYC       = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                WR_VALID,
   output logic                WR_READY,
   input  logic [SECT_W-1:0]   WR_SECT,
   input  logic [2:0]          WR_IDX,
   input  logic [15:0]         WR_DATA,
   input  logic                COMMIT_REQ,
   output logic                COMMIT_ACK,
   input  logic                SAMPLE_STB,
   output logic [N_SECT*80-1:0] COEF_OUT,
   output logic                FLUSH,
   output logic                BUSY,
   output logic                ERR
);

   localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [15:0] UNITY = 16'h4000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PEND,
      S_SWAP,
      S_FLSH
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          err_q, err_d;

   logic [15:0] shadow_q [N_SECT][5];
   logic [15:0] shadow_d [N_SECT][5];
   logic [15:0] active_q [N_SECT][5];
   logic [15:0] active_d [N_SECT][5];

   logic wr_rdy;
   logic wr_acc;
   logic wr_legal;

   assign wr_rdy   = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign wr_acc   = WR_VALID && wr_rdy;
   assign wr_legal = (WR_IDX <= 3'd4) && (int'(WR_SECT) < N_SECT);

   assign WR_READY = wr_rdy;
   assign ERR      = err_q;

   // control FSM
   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      err_d      = err_q;
      COMMIT_ACK = 1'b0;
      FLUSH      = 1'b0;
      BUSY       = 1'b0;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (wr_acc) begin
               if (wr_legal) state_d = S_LOAD;
               else          err_d   = 1'b1;
            end
            // a same-cycle write lands in shadow before the swap
            if (COMMIT_REQ) state_d = S_PEND;
         end
         S_PEND: begin
            BUSY = 1'b1;
            if (SAMPLE_STB) state_d = S_SWAP;
         end
         S_SWAP: begin
            BUSY       = 1'b1;
            COMMIT_ACK = 1'b1;
            err_d      = 1'b0;
            if (FLUSH_ON_COMMIT) begin
               state_d = S_FLSH;
               fcnt_d  = CW'(FLUSH_CYC - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLSH: begin
            BUSY  = 1'b1;
            FLUSH = 1'b1;
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         err_q   <= err_d;
      end
   end

   // shadow bank: host writes
   always_comb begin
      shadow_d = shadow_q;
      for (int s = 0; s < N_SECT; s++) begin
         for (int k = 0; k < 5; k++) begin
            if (wr_acc && wr_legal &&
                int'(WR_SECT) == s &&
                int'(WR_IDX) == k)
               shadow_d[s][k] = WR_DATA;
         end
      end
   end

   // active bank: whole-bank copy in the swap cycle only
   always_comb begin
      active_d = active_q;
      if (state_q == S_SWAP)
         active_d = shadow_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int s = 0; s < N_SECT; s++) begin
            for (int k = 0; k < 5; k++) begin
               shadow_q[s][k] <= (k == 0) ? UNITY : 16'h0000;
               active_q[s][k] <= (k == 0) ? UNITY : 16'h0000;
            end
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      COEF_OUT = '0;
      for (int s = 0; s < N_SECT; s++) begin
         for (int k = 0; k < 5; k++) begin
            COEF_OUT[s*80 + k*16 +: 16] = active_q[s][k];
         end
      end
   end

endmodule

// File: tb/tb_biquad_coef_ctrl.sv
// Bench for biquad_coef_ctrl: two instances (4 sect + flush,
// 3 sect no flush) share stimulus and are checked against bank arrays.
module tb_biquad_coef_ctrl;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          WR_VALID = 1'b0;
   logic [1:0]    WR_SECT = '0;
   logic [2:0]    WR_IDX = '0;
   logic [15:0]   WR_DATA = '0;
   logic          COMMIT_REQ = 1'b0;
   logic          SAMPLE_STB = 1'b0;

   logic          rdy_a, ack_a, fl_a, busy_a, err_a;
   logic          rdy_b, ack_b, fl_b, busy_b, err_b;
   logic [319:0]  coef_a;
   logic [239:0]  coef_b;

   int ncomp = 0;
   int nfail = 0;

   logic [15:0] msh [2][4][5];
   logic [15:0] mac [2][4][5];
   logic        merr [2];
   int          nsect [2];

   always #5 CLK = ~CLK;

   biquad_coef_ctrl #(
      .N_SECT(4), .SECT_W(2),
      .FLUSH_ON_COMMIT(1'b1), .FLUSH_CYC(2)
   ) u_a (
      .CLK(CLK), .RST(RST),
      .WR_VALID(WR_VALID), .WR_READY(rdy_a),
      .WR_SECT(WR_SECT), .WR_IDX(WR_IDX), .WR_DATA(WR_DATA),
      .COMMIT_REQ(COMMIT_REQ), .COMMIT_ACK(ack_a),
      .SAMPLE_STB(SAMPLE_STB), .COEF_OUT(coef_a),
      .FLUSH(fl_a), .BUSY(busy_a), .ERR(err_a)
   );

   biquad_coef_ctrl #(
      .N_SECT(3), .SECT_W(2),
      .FLUSH_ON_COMMIT(1'b0), .FLUSH_CYC(2)
   ) u_b (
      .CLK(CLK), .RST(RST),
      .WR_VALID(WR_VALID), .WR_READY(rdy_b),
      .WR_SECT(WR_SECT), .WR_IDX(WR_IDX), .WR_DATA(WR_DATA),
      .COMMIT_REQ(COMMIT_REQ), .COMMIT_ACK(ack_b),
      .SAMPLE_STB(SAMPLE_STB), .COEF_OUT(coef_b),
      .FLUSH(fl_b), .BUSY(busy_b), .ERR(err_b)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         merr[i] = 1'b0;
         for (int s = 0; s < 4; s++)
            for (int k = 0; k < 5; k++) begin
               msh[i][s][k] = (k == 0) ? 16'h4000 : 16'h0000;
               mac[i][s][k] = (k == 0) ? 16'h4000 : 16'h0000;
            end
      end
   endtask

   task automatic model_write(input int sect, input int idx,
                              input logic [15:0] data);
      for (int i = 0; i < 2; i++) begin
         if (idx <= 4 && sect < nsect[i]) msh[i][sect][idx] = data;
         else                             merr[i] = 1'b1;
      end
   endtask

   task automatic chk_coef(input string tag);
      logic [15:0] o;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 5; k++) begin
            o = coef_a[s*80 + k*16 +: 16];
            chk({tag, "_a"}, {16'h0, o}, {16'h0, mac[0][s][k]});
         end
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < 5; k++) begin
            o = coef_b[s*80 + k*16 +: 16];
            chk({tag, "_b"}, {16'h0, o}, {16'h0, mac[1][s][k]});
         end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy_a"}, 32'(rdy_a), 32'd1);
      chk({tag, "_rdy_b"}, 32'(rdy_b), 32'd1);
      chk({tag, "_busy_a"}, 32'(busy_a), 32'd0);
      chk({tag, "_busy_b"}, 32'(busy_b), 32'd0);
      chk({tag, "_ack_a"}, 32'(ack_a), 32'd0);
      chk({tag, "_ack_b"}, 32'(ack_b), 32'd0);
      chk({tag, "_fl_a"}, 32'(fl_a), 32'd0);
      chk({tag, "_fl_b"}, 32'(fl_b), 32'd0);
      chk({tag, "_err_a"}, 32'(err_a), 32'(merr[0]));
      chk({tag, "_err_b"}, 32'(err_b), 32'(merr[1]));
   endtask

   task automatic do_write(input int sect, input int idx,
                           input logic [15:0] data);
      chk("wr_rdy_a", 32'(rdy_a), 32'd1);
      chk("wr_rdy_b", 32'(rdy_b), 32'd1);
      WR_VALID = 1'b1;
      WR_SECT  = 2'(sect);
      WR_IDX   = 3'(idx);
      WR_DATA  = data;
      step();
      WR_VALID = 1'b0;
      model_write(sect, idx, data);
      chk("wr_err_a", 32'(err_a), 32'(merr[0]));
      chk("wr_err_b", 32'(err_b), 32'(merr[1]));
   endtask

   // from PEND: strobe, then check swap, coefficient update and flush
   task automatic strobe_swap();
      SAMPLE_STB = 1'b1;
      step();
      SAMPLE_STB = 1'b0;
      chk("swap_ack_a", 32'(ack_a), 32'd1);
      chk("swap_ack_b", 32'(ack_b), 32'd1);
      chk("swap_busy_a", 32'(busy_a), 32'd1);
      chk_coef("swap_old");
      for (int i = 0; i < 2; i++) begin
         merr[i] = 1'b0;
         for (int s = 0; s < 4; s++)
            for (int k = 0; k < 5; k++)
               mac[i][s][k] = msh[i][s][k];
      end
      step();
      chk_coef("swap_new");
      chk("post_ack_a", 32'(ack_a), 32'd0);
      chk("post_ack_b", 32'(ack_b), 32'd0);
      chk("fl1_a", 32'(fl_a), 32'd1);
      chk("fl1_b", 32'(fl_b), 32'd0);
      chk("post_busy_b", 32'(busy_b), 32'd0);
      chk("post_rdy_b", 32'(rdy_b), 32'd1);
      chk("post_rdy_a", 32'(rdy_a), 32'd0);
      chk("post_err_a", 32'(err_a), 32'd0);
      chk("post_err_b", 32'(err_b), 32'd0);
      SAMPLE_STB = 1'b1;
      step();
      SAMPLE_STB = 1'b0;
      chk("fl2_a", 32'(fl_a), 32'd1);
      chk("fl2_ack_a", 32'(ack_a), 32'd0);
      step();
      chk_idle("flush_done");
   endtask

   task automatic do_swap(input int wait_n);
      COMMIT_REQ = 1'b1;
      step();
      COMMIT_REQ = 1'b0;
      for (int c = 0; c < wait_n; c++) begin
         chk("pend_busy_a", 32'(busy_a), 32'd1);
         chk("pend_busy_b", 32'(busy_b), 32'd1);
         chk("pend_rdy_a", 32'(rdy_a), 32'd0);
         chk("pend_ack_a", 32'(ack_a), 32'd0);
         chk("pend_ack_b", 32'(ack_b), 32'd0);
         chk_coef("pend_coef");
         step();
      end
      strobe_swap();
   endtask

   initial begin
      nsect[0] = 4;
      nsect[1] = 3;
      model_reset();

      // reset state
      step();
      step();
      RST = 1'b1;
      step();
      chk_idle("reset");
      chk_coef("reset");

      // single write, commit, strobe 5 cycles later
      do_write(2, 3, 16'hC000);
      chk_coef("wr_no_active");
      do_swap(5);
      chk("c000_a", {16'h0, coef_a[2*80+48 +: 16]}, 32'h0000C000);

      // illegal writes: idx 5 on both, sect 3 only on 3-section unit
      do_write(0, 5, 16'h1234);
      do_write(3, 1, 16'h5555);
      chk("err_a", 32'(err_a), 32'd1);
      chk("err_b", 32'(err_b), 32'd1);
      chk_coef("err_coef");
      do_swap(2);

      // write + commit + strobe in one cycle, blocked writes in PEND
      WR_VALID   = 1'b1;
      WR_SECT    = 2'd0;
      WR_IDX     = 3'd0;
      WR_DATA    = 16'h2000;
      COMMIT_REQ = 1'b1;
      SAMPLE_STB = 1'b1;
      step();
      COMMIT_REQ = 1'b0;
      SAMPLE_STB = 1'b0;
      model_write(0, 0, 16'h2000);
      WR_DATA = 16'h7777;
      for (int c = 0; c < 3; c++) begin
         chk("pend_wr_rdy_a", 32'(rdy_a), 32'd0);
         chk("pend_wr_rdy_b", 32'(rdy_b), 32'd0);
         chk("same_ack_a", 32'(ack_a), 32'd0);
         chk("same_busy_a", 32'(busy_a), 32'd1);
         step();
      end
      WR_VALID = 1'b0;
      chk_coef("pend_hold");
      strobe_swap();
      chk("b0_2000_a", {16'h0, coef_a[15:0]}, 32'h00002000);

      // commit from IDLE with no writes
      do_swap(3);

      // randomized rounds
      for (int r = 0; r < 8; r++) begin
         int nw;
         nw = int'($urandom_range(1, 6));
         for (int w = 0; w < nw; w++)
            do_write(int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)),
                     16'($urandom));
         do_swap(int'($urandom_range(0, 4)));
      end

      // reset in the middle of PEND
      do_write(1, 1, 16'h1111);
      COMMIT_REQ = 1'b1;
      step();
      COMMIT_REQ = 1'b0;
      step();
      chk("rst_pre_busy", 32'(busy_a), 32'd1);
      #2;
      RST = 1'b0;
      #1;
      model_reset();
      chk_idle("async_rst");
      chk_coef("async_rst");
      #2;
      RST = 1'b1;
      step();
      SAMPLE_STB = 1'b1;
      step();
      SAMPLE_STB = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_idle("rst_no_ack");
         step();
      end
      chk_coef("rst_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncomp, nfail);
      $finish;
   end

endmodule
